// File: rtl/box_h_3_window_sequencer.sv
// Raster pixel stream to 1x3 horizontal windows with edge replication at the
// left/right borders, plus centre column/row coordinates and a frame-end pulse.
// One flush cycle per line (input stalled) emits the last column's window.
module box_h_3_window_sequencer #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  pixel_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [7:0]  window_o [0:0][0:2],
  output logic [15:0] col_o,
  output logic [15:0] row_o,
  output logic        valid_o,
  output logic        frame_done_o
);

  localparam int unsigned PW = 8;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    LINE_START = 2'd0,
    FILL       = 2'd1,
    RUN        = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] prev1, prev1_n;
  logic [PW-1:0] prev2, prev2_n;
  logic [CW-1:0] col_cnt, col_cnt_n;
  logic [CW-1:0] row_cnt, row_cnt_n;

  logic [PW-1:0] win_l_n, win_c_n, win_r_n;
  logic [CW-1:0] col_n, row_n;
  logic          valid_n, frame_done_n, ready_n;

  logic          accept;

  // A beat is taken only when the source offers it and we are not flushing.
  assign accept = valid_i & ready_o;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= LINE_START;
    end else begin
      state <= state_n;
    end
  end

  // Taps, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      prev1          <= '0;
      prev2          <= '0;
      col_cnt        <= '0;
      row_cnt        <= '0;
      window_o[0][0] <= '0;
      window_o[0][1] <= '0;
      window_o[0][2] <= '0;
      col_o          <= '0;
      row_o          <= '0;
      valid_o        <= 1'b0;
      frame_done_o   <= 1'b0;
      ready_o        <= 1'b1;
    end else begin
      prev1          <= prev1_n;
      prev2          <= prev2_n;
      col_cnt        <= col_cnt_n;
      row_cnt        <= row_cnt_n;
      window_o[0][0] <= win_l_n;
      window_o[0][1] <= win_c_n;
      window_o[0][2] <= win_r_n;
      col_o          <= col_n;
      row_o          <= row_n;
      valid_o        <= valid_n;
      frame_done_o   <= frame_done_n;
      ready_o        <= ready_n;
    end
  end

  // Next-state and next-output logic; window/col/row hold unless a window is emitted.
  always_comb begin
    state_n      = state;
    prev1_n      = prev1;
    prev2_n      = prev2;
    col_cnt_n    = col_cnt;
    row_cnt_n    = row_cnt;
    win_l_n      = window_o[0][0];
    win_c_n      = window_o[0][1];
    win_r_n      = window_o[0][2];
    col_n        = col_o;
    row_n        = row_o;
    valid_n      = 1'b0;
    frame_done_n = 1'b0;
    ready_n      = 1'b1;

    unique case (state)
      LINE_START: begin
        if (accept) begin
          prev1_n   = pixel_i;
          col_cnt_n = CW'(1);
          state_n   = FILL;
        end
      end

      FILL: begin
        if (accept) begin
          win_l_n   = prev1;
          win_c_n   = prev1;
          win_r_n   = pixel_i;
          col_n     = '0;
          row_n     = row_cnt;
          valid_n   = 1'b1;
          prev2_n   = prev1;
          prev1_n   = pixel_i;
          col_cnt_n = CW'(2);
          if (WIDTH == 2) begin
            state_n = FLUSH;
            ready_n = 1'b0;
          end else begin
            state_n = RUN;
          end
        end
      end

      RUN: begin
        if (accept) begin
          win_l_n = prev2;
          win_c_n = prev1;
          win_r_n = pixel_i;
          col_n   = CW'(col_cnt - CW'(1));
          row_n   = row_cnt;
          valid_n = 1'b1;
          prev2_n = prev1;
          prev1_n = pixel_i;
          if (col_cnt == CW'(WIDTH - 1)) begin
            state_n = FLUSH;
            ready_n = 1'b0;
          end else begin
            col_cnt_n = CW'(col_cnt + CW'(1));
          end
        end
      end

      FLUSH: begin
        // Right border: replicate the last pixel of the line.
        win_l_n   = prev2;
        win_c_n   = prev1;
        win_r_n   = prev1;
        col_n     = CW'(WIDTH - 1);
        row_n     = row_cnt;
        valid_n   = 1'b1;
        col_cnt_n = '0;
        if (row_cnt == CW'(HEIGHT - 1)) begin
          frame_done_n = 1'b1;
          row_cnt_n    = '0;
        end else begin
          row_cnt_n = CW'(row_cnt + CW'(1));
        end
        state_n = LINE_START;
      end

      default: begin
        state_n = LINE_START;
      end
    endcase
  end

endmodule
